// File: rtl/dram_cmd_responder.sv
// Memory-side responder for the controller command handshake: tracks per-bank open rows,
// models ACT/RD/WR/PRE latency and acks 4-phase. Optional refresh under DRAM_RESP_REFRESH_EN.
module dram_cmd_responder #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int T_RCD  = 3,
  parameter int T_CAS  = 2,
  parameter int T_WR   = 2,
  parameter int T_RP   = 3,
  parameter int T_REFI = 64,
  parameter int T_RFC  = 8,
  localparam int BW    = $clog2(NUMBER_OF_BANKS)
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       cmd_req,
  input  logic [1:0]                 cmd,
  input  logic [BW-1:0]              bank_rw,
  input  logic [BW-1:0]              buf_rw,
  output logic                       cmd_ack,
  output logic                       cmd_err,
  output logic [BW-1:0]              resp_buf,
  output logic                       rd_valid,
  output logic                       wr_done,
  output logic [NUMBER_OF_BANKS-1:0] bank_open,
`ifdef DRAM_RESP_REFRESH_EN
  output logic                       refresh_flag,
`endif
  output logic                       busy
);

  localparam logic [1:0] C_ACT = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_PRE = 2'b11;
  localparam int M1    = (T_RCD > T_CAS) ? T_RCD : T_CAS;
  localparam int M2    = (T_WR  > T_RP)  ? T_WR  : T_RP;
  localparam int M3    = (M1 > M2) ? M1 : M2;
  localparam int T_MAX = (M3 > T_RFC) ? M3 : T_RFC;
  localparam int TW    = $clog2(T_MAX) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, REFRESH} state_t;

  state_t                     state, state_d;
  logic [TW-1:0]              timer, timer_d;
  logic [1:0]                 cmd_q, cmd_d;
  logic [BW-1:0]              bank_q, bank_d, buf_d;
  logic                       ack_d, err_d, rdv_d, wrd_d;
  logic [NUMBER_OF_BANKS-1:0] open_d;
  logic                       illegal;

`ifdef DRAM_RESP_REFRESH_EN
  localparam int RW = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  logic [RW-1:0] ref_cnt, ref_cnt_d;
  logic          flag_d, ref_wrap;
`endif

  // ACTIVATE needs a closed bank; everything else needs it open
  assign illegal = (cmd == C_ACT) ? bank_open[bank_rw] : !bank_open[bank_rw];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state     <= IDLE;
      timer     <= '0;
      cmd_q     <= '0;
      bank_q    <= '0;
      resp_buf  <= '0;
      cmd_ack   <= 1'b0;
      cmd_err   <= 1'b0;
      rd_valid  <= 1'b0;
      wr_done   <= 1'b0;
      bank_open <= '0;
`ifdef DRAM_RESP_REFRESH_EN
      ref_cnt      <= '0;
      refresh_flag <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      cmd_q     <= cmd_d;
      bank_q    <= bank_d;
      resp_buf  <= buf_d;
      cmd_ack   <= ack_d;
      cmd_err   <= err_d;
      rd_valid  <= rdv_d;
      wr_done   <= wrd_d;
      bank_open <= open_d;
`ifdef DRAM_RESP_REFRESH_EN
      ref_cnt      <= ref_cnt_d;
      refresh_flag <= flag_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    cmd_d   = cmd_q;
    bank_d  = bank_q;
    buf_d   = resp_buf;
    ack_d   = cmd_ack;
    err_d   = cmd_err;
    rdv_d   = 1'b0;
    wrd_d   = 1'b0;
    open_d  = bank_open;
`ifdef DRAM_RESP_REFRESH_EN
    ref_wrap  = (ref_cnt == RW'(T_REFI - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt + 1'b1;
    flag_d    = refresh_flag | ref_wrap;
`endif
    unique case (state)
      IDLE: begin
`ifdef DRAM_RESP_REFRESH_EN
        if (refresh_flag && bank_open == '0) begin
          state_d = REFRESH;
          timer_d = TW'(T_RFC - 1);
        end else
`endif
        if (cmd_req) begin
          cmd_d  = cmd;
          bank_d = bank_rw;
          buf_d  = buf_rw;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else begin
            state_d = WAIT;
            unique case (cmd)
              C_ACT:   timer_d = TW'(T_RCD - 1);
              C_RD:    timer_d = TW'(T_CAS - 1);
              C_WR:    timer_d = TW'(T_WR - 1);
              default: timer_d = TW'(T_RP - 1);
            endcase
          end
        end
      end
      WAIT: begin
        if (timer == '0) begin
          unique case (cmd_q)
            C_ACT:   open_d[bank_q] = 1'b1;
            C_RD:    rdv_d = 1'b1;
            C_WR:    wrd_d = 1'b1;
            default: open_d[bank_q] = 1'b0;
          endcase
          state_d = ACK;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      ACK: begin
        if (cmd_req) begin
          ack_d = 1'b1;
        end else begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
`ifdef DRAM_RESP_REFRESH_EN
        // a new interval elapsing on the exit edge keeps the flag set
        if (timer == '0) begin
          state_d = IDLE;
          flag_d  = ref_wrap;
        end else begin
          timer_d = timer - 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder: scoreboard queue of expected responses popped on cmd_ack.
module tb_dram_cmd_responder;
  localparam int NB = 8, BW = 3;
  localparam int T_RCD = 3, T_CAS = 2, T_WR = 2, T_RP = 3, T_REFI = 64, T_RFC = 8;

  logic          clk = 1'b0, rst_b = 1'b1, cmd_req = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic [BW-1:0] bank_rw = '0, buf_rw = '0;
  logic          cmd_ack, cmd_err, rd_valid, wr_done, busy;
  logic [BW-1:0] resp_buf;
  logic [NB-1:0] bank_open;
`ifdef DRAM_RESP_REFRESH_EN
  logic          refresh_flag;
`endif

  int total = 0, bad = 0;

  typedef struct {
    logic          err;
    int            lat;
    logic [BW-1:0] bufv;
    int            nrd, nwr;
    logic [NB-1:0] open;
  } exp_t;
  exp_t sb[$];

  dram_cmd_responder #(.NUMBER_OF_BANKS(NB), .T_RCD(T_RCD), .T_CAS(T_CAS), .T_WR(T_WR),
                       .T_RP(T_RP), .T_REFI(T_REFI), .T_RFC(T_RFC)) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd), .bank_rw(bank_rw),
    .buf_rw(buf_rw), .cmd_ack(cmd_ack), .cmd_err(cmd_err), .resp_buf(resp_buf),
    .rd_valid(rd_valid), .wr_done(wr_done), .bank_open(bank_open),
`ifdef DRAM_RESP_REFRESH_EN
    .refresh_flag(refresh_flag),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, scramble the inputs while busy, collect the response against the scoreboard.
  task automatic do_cmd(input string tag, input logic [1:0] c, input int bank, input int bf,
                        input logic err, input int lat, input int nrd, input int nwr,
                        input logic [NB-1:0] open);
    exp_t e, got;
    int   l, rd_cnt = 0, wr_cnt = 0;
    bit   seen = 0;
    e.err = err; e.lat = lat; e.bufv = BW'(bf); e.nrd = nrd; e.nwr = nwr; e.open = open;
    sb.push_back(e);
    cmd = c; bank_rw = BW'(bank); buf_rw = BW'(bf); cmd_req = 1'b1;
    for (l = 0; l < 40; l++) begin
      tick();
      if (l == 0) begin
        cmd = ~c; bank_rw = ~BW'(bank); buf_rw = ~BW'(bf);
      end
      rd_cnt += int'(rd_valid);
      wr_cnt += int'(wr_done);
      if (cmd_ack) begin
        seen = 1;
        break;
      end
    end
    got = sb.pop_front();
    chk({tag, " ack_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, l, got.lat);
    chk({tag, " cmd_err"}, 32'(cmd_err), 32'(got.err));
    chk({tag, " resp_buf"}, 32'(resp_buf), 32'(got.bufv));
    chk({tag, " rd_pulses"}, rd_cnt, got.nrd);
    chk({tag, " wr_pulses"}, wr_cnt, got.nwr);
    chk({tag, " bank_open"}, 32'(bank_open), 32'(got.open));
    cmd_req = 1'b0;
    tick();
    chk({tag, " ack_drop"}, 32'(cmd_ack), 32'd0);
    chk({tag, " err_drop"}, 32'(cmd_err), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst ack", 32'(cmd_ack), 32'd0);
      chk("rst open", 32'(bank_open), 32'd0);
    end
    chk("rst err", 32'(cmd_err), 32'd0);
    chk("rst buf", 32'(resp_buf), 32'd0);
    chk("rst pulses", {rd_valid, wr_done}, 32'd0);

    do_cmd("act5",     2'b00, 5, 2, 1'b0, T_RCD + 1, 0, 0, 8'h20);
    do_cmd("rd5",      2'b01, 5, 1, 1'b0, T_CAS + 1, 1, 0, 8'h20);
    do_cmd("wr5",      2'b10, 5, 6, 1'b0, T_WR + 1,  0, 1, 8'h20);
    do_cmd("rd3_ill",  2'b01, 3, 4, 1'b1, 1,         0, 0, 8'h20);
    do_cmd("act5_ill", 2'b00, 5, 7, 1'b1, 1,         0, 0, 8'h20);
    do_cmd("pre2_ill", 2'b11, 2, 3, 1'b1, 1,         0, 0, 8'h20);
    do_cmd("act0",     2'b00, 0, 0, 1'b0, T_RCD + 1, 0, 0, 8'h21);
    do_cmd("act7",     2'b00, 7, 5, 1'b0, T_RCD + 1, 0, 0, 8'hA1);
    do_cmd("pre0",     2'b11, 0, 1, 1'b0, T_RP + 1,  0, 0, 8'hA0);
    do_cmd("pre7",     2'b11, 7, 7, 1'b0, T_RP + 1,  0, 0, 8'h20);

    // reset in the middle of an ACTIVATE wait, with bank 5 still open
    cmd = 2'b00; bank_rw = 3'd1; buf_rw = 3'd0; cmd_req = 1'b1;
    tick();
    tick();
    chk("mid busy", 32'(busy), 32'd1);
    rst_b = 1'b1; cmd_req = 1'b0;
    tick();
    rst_b = 1'b0;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst open", 32'(bank_open), 32'd0);
    chk("mid rst ack", 32'(cmd_ack), 32'd0);
    tick();

    do_cmd("act5b",    2'b00, 5, 3, 1'b0, T_RCD + 1, 0, 0, 8'h20);
    do_cmd("pre5",     2'b11, 5, 6, 1'b0, T_RP + 1,  0, 0, 8'h00);

`ifdef DRAM_RESP_REFRESH_EN
    begin
      bit fl = 0, ak = 0;
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      for (int i = 0; i < T_REFI + 10; i++) begin
        tick();
        if (refresh_flag) begin fl = 1; break; end
      end
      chk("ref flag", 32'(fl), 32'd1);
      cmd = 2'b00; bank_rw = 3'd2; buf_rw = 3'd4;
      for (int i = 0; i < T_RFC; i++) begin
        tick();
        cmd_req = 1'b1;
        chk("ref busy", 32'(busy), 32'd1);
        chk("ref no ack", 32'(cmd_ack), 32'd0);
      end
      for (int i = 0; i < 30; i++) begin
        tick();
        if (cmd_ack) begin ak = 1; break; end
      end
      chk("ref ack", 32'(ak), 32'd1);
      chk("ref flag clr", 32'(refresh_flag), 32'd0);
      cmd_req = 1'b0;
      tick();
    end
`endif

    chk("sb empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
- Memory-side responder for the controller FSM's command handshake: accepts cmd_req/cmd/bank_rw/buf_rw, models per-bank row state and DRAM timing, and returns cmd_ack.
- Sits between dram_ctrl_fsm and the bank array model.
- Serves as the synthesizable bank-timing endpoint and as the standalone partner for FSM benches.

Parameters:
- NUMBER_OF_BANKS, 8, bank count; bank index width is $clog2(NUMBER_OF_BANKS).
- T_RCD, 3, ACTIVATE latency in cycles (minimum 1).
- T_CAS, 2, READ latency in cycles (minimum 1).
- T_WR, 2, WRITE latency in cycles (minimum 1).
- T_RP, 3, PRECHARGE latency in cycles (minimum 1).
- T_REFI, 64, refresh interval in cycles (optional feature only).
- T_RFC, 8, refresh duration in cycles (optional feature only).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  synchronous, active-high reset.
- cmd_req  in  1  command request, held high until cmd_ack is seen.
- cmd  in  2  command: 00 ACTIVATE, 01 READ, 10 WRITE, 11 PRECHARGE.
- bank_rw  in  $clog2(NUMBER_OF_BANKS)  target bank.
- buf_rw  in  $clog2(NUMBER_OF_BANKS)  buffer slot tag; captured with the command and echoed on resp_buf.
- cmd_ack  out  1  acknowledge, 4-phase.
- cmd_err  out  1  illegal command flag; valid while cmd_ack is high.
- resp_buf  out  $clog2(NUMBER_OF_BANKS)  captured buf_rw, valid while cmd_ack is high.
- rd_valid  out  1  one-cycle pulse at completion of a legal READ.
- wr_done  out  1  one-cycle pulse at completion of a legal WRITE.
- bank_open  out  NUMBER_OF_BANKS  per-bank open-row bits.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_b high at a clock edge) wins over everything, including mid-handshake.
  - Reset state: IDLE.
  - All outputs reset to 0: cmd_ack, cmd_err, resp_buf, rd_valid, wr_done, bank_open, busy.
  - Counters reset to 0.
- States: IDLE, WAIT, ACK, and REFRESH (REFRESH exists only with the optional feature).
- IDLE, on cmd_req=1:
  - Capture cmd, bank_rw and buf_rw.
  - Legality check against bank_open[bank_rw]:
    - ACTIVATE is illegal if the bank is open.
    - READ, WRITE and PRECHARGE are illegal if the bank is closed.
  - Legal command: load the timer with T_x-1 and go to WAIT.
  - Illegal command: set cmd_err=1 and go directly to ACK; bank_open is unchanged.
- WAIT: the timer decrements each cycle. At timer==0:
  - ACTIVATE sets bank_open[bank]=1.
  - PRECHARGE clears bank_open[bank].
  - READ pulses rd_valid for one cycle; WRITE pulses wr_done for one cycle.
  - Go to ACK.
- ACK: cmd_ack=1 while cmd_req=1. When cmd_req is sampled 0:
  - Deassert cmd_ack and cmd_err on the next edge.
  - Return to IDLE.
  - The next request is sampled no earlier than the cycle after return to IDLE.
- Latency, from the edge where cmd_req is sampled in IDLE to cmd_ack high:
  - Legal command: T_x+1 cycles.
  - Illegal command: 1 cycle.
- Commands are not pipelined: one outstanding command at a time.
- While busy, changes on cmd, bank_rw and buf_rw are ignored, since they are captured in IDLE.
- cmd_req dropping before cmd_ack is a protocol violation. The command still completes, and ACK exits on the first cycle.
- Timers are $clog2 of the maximum T value plus 1 bit wide and do not wrap.

Optional Feature:
- Macro: DRAM_RESP_REFRESH_EN.
- When defined:
  - Adds output refresh_flag (1 bit) and a free-running interval counter.
  - The counter reaching T_REFI-1 sets refresh_flag=1 and wraps to 0.
  - In IDLE, with refresh_flag=1 and bank_open==0, enter REFRESH. REFRESH takes precedence over a simultaneous cmd_req.
  - REFRESH lasts T_RFC cycles with busy=1 and no request sampled. On exit, refresh_flag clears.
  - Commands are still served while the flag is pending and banks are open.
  - refresh_flag resets to 0.
- When not defined: no refresh_flag port, no REFRESH state, no interval counter.

Test Plan:
- Reset: hold rst_b=1 for 3 cycles, then release. Over 10 idle cycles, require busy=0, cmd_ack=0 and bank_open=8'h00.
- Activate: cmd=00, bank_rw=5, buf_rw=2, cmd_req=1. Require cmd_ack exactly 4 cycles later with resp_buf=2 and cmd_err=0, and bank_open=8'h20. Drop cmd_req and require cmd_ack=0 the next cycle.
- Read/write on open bank 5: READ gives rd_valid pulsing once and cmd_ack 3 cycles after sampling. WRITE gives one wr_done pulse and cmd_ack after 3 cycles.
- Illegal: READ to closed bank 3 gives cmd_ack 1 cycle later with cmd_err=1 and bank_open unchanged. ACTIVATE to open bank 5 likewise gives cmd_err=1.
- Precharge bank 5 gives cmd_ack after 4 cycles and bank_open=8'h00.
- Reset mid-WAIT on an ACTIVATE to bank 1: require IDLE next cycle, bank_open=0 and cmd_ack=0. With DRAM_RESP_REFRESH_EN: after 64 cycles refresh_flag=1 and busy=1 for 8 cycles; a cmd_req raised during refresh is acked only after refresh_flag clears.
